// File: rtl/io_arb_pkg.sv
// Shared types and constants for the two-master I/O bus arbiter.
package io_arb_pkg;

   localparam int IO_ADDR_W = 8;
   localparam int IO_DATA_W = 8;

   localparam logic M_CPU = 1'b0;
   localparam logic M_AUX = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RWAIT = 2'd2,
      ACK   = 2'd3
   } arb_state_e;

   typedef struct packed {
      logic                 we;
      logic [IO_ADDR_W-1:0] addr;
      logic [IO_DATA_W-1:0] wdata;
   } io_cmd_t;

endpackage

// File: rtl/io_arb_pick.sv
// Combinational winner selection between the two masters.
// IO_ARB_ROUND_ROBIN_EN selects round-robin on ties; otherwise master 0 always wins.
module io_arb_pick
   import io_arb_pkg::*;
(
   input  logic req0_i,
   input  logic req1_i,
   input  logic prio_i,
   output logic gnt_valid_o,
   output logic winner_o
);

   // Tie-break: prio_i names the master preferred on a simultaneous request.
   always_comb begin
      gnt_valid_o = req0_i | req1_i;
`ifdef IO_ARB_ROUND_ROBIN_EN
      if (req0_i && req1_i) begin
         winner_o = prio_i;
      end else if (req1_i) begin
         winner_o = M_AUX;
      end else begin
         winner_o = M_CPU;
      end
`else
      if (req0_i) begin
         winner_o = M_CPU;
      end else if (req1_i) begin
         winner_o = M_AUX;
      end else begin
         winner_o = M_CPU;
      end
`endif
   end

`ifndef IO_ARB_ROUND_ROBIN_EN
   logic unused_prio;
   assign unused_prio = prio_i;
`endif

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master arbiter/sequencer for the shared peripheral I/O bus.
// Define IO_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority to master 0.
module io_bus_arbiter
   import io_arb_pkg::*;
#(
   parameter int ADDR_W = IO_ADDR_W,
   parameter int DATA_W = IO_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_dout,
   output logic              bus_w_en,
   output logic              bus_r_en,
   input  logic [DATA_W-1:0] bus_din,
   output logic              busy
);

   arb_state_e        state_q, state_d;
   io_cmd_t           cmd_q, cmd_d;
   logic              owner_q, owner_d;
   logic              prio_q, prio_d;
   logic              w_en_q, w_en_d;
   logic              r_en_q, r_en_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic              busy_q, busy_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              gnt_valid;
   logic              winner;

   io_arb_pick u_pick (
      .req0_i      (m0_req),
      .req1_i      (m1_req),
      .prio_i      (prio_q),
      .gnt_valid_o (gnt_valid),
      .winner_o    (winner)
   );

   // Next-state logic; outputs are computed one cycle ahead so they leave flops.
   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      owner_d  = owner_q;
      prio_d   = prio_q;
      w_en_d   = 1'b0;
      r_en_d   = 1'b0;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               owner_d = winner;
               if (winner == M_AUX) begin
                  cmd_d = '{we: m1_we, addr: m1_addr, wdata: m1_wdata};
               end else begin
                  cmd_d = '{we: m0_we, addr: m0_addr, wdata: m0_wdata};
               end
               w_en_d  = cmd_d.we;
               r_en_d  = ~cmd_d.we;
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (cmd_q.we) begin
               ack0_d  = (owner_q == M_CPU);
               ack1_d  = (owner_q == M_AUX);
               state_d = ACK;
            end else begin
               state_d = RWAIT;
            end
         end
         RWAIT: begin
            // Peripherals register dout, so bus_din is valid one cycle after the strobe.
            if (owner_q == M_AUX) begin
               rdata1_d = bus_din;
            end else begin
               rdata0_d = bus_din;
            end
            ack0_d  = (owner_q == M_CPU);
            ack1_d  = (owner_q == M_AUX);
            state_d = ACK;
         end
         ACK: begin
            prio_d  = ~owner_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cmd_q    <= '0;
         owner_q  <= M_CPU;
         prio_q   <= M_CPU;
         w_en_q   <= 1'b0;
         r_en_q   <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         busy_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         owner_q  <= owner_d;
         prio_q   <= prio_d;
         w_en_q   <= w_en_d;
         r_en_q   <= r_en_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         busy_q   <= busy_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign bus_addr = cmd_q.addr;
   assign bus_dout = cmd_q.wdata;
   assign bus_w_en = w_en_q;
   assign bus_r_en = r_en_q;
   assign m0_ack   = ack0_q;
   assign m1_ack   = ack1_q;
   assign m0_rdata = rdata0_q;
   assign m1_rdata = rdata1_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Randomized bench for io_bus_arbiter with a transaction-timing reference model.
module tb_io_bus_arbiter;

   logic       clk;
   logic       rst;
   logic       req   [2];
   logic       we    [2];
   logic [7:0] addr  [2];
   logic [7:0] wd    [2];
   logic       m0_ack, m1_ack;
   logic [7:0] m0_rdata, m1_rdata;
   logic [7:0] bus_addr, bus_dout, bus_din;
   logic       bus_w_en, bus_r_en, busy;

   int n_cmp = 0;
   int n_mis = 0;

   // reference model: expected outputs for the current cycle
   bit       act;
   int       ph;
   int       m_owner;
   bit       m_we;
   int       pref;
   bit       e_ack [2];
   bit       e_wen, e_ren, e_busy;
   bit [7:0] e_addr, e_dout;
   bit [7:0] e_rd [2];

   io_bus_arbiter dut (
      .clk(clk), .rst(rst),
      .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wd[0]),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wd[1]),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .bus_addr(bus_addr), .bus_dout(bus_dout),
      .bus_w_en(bus_w_en), .bus_r_en(bus_r_en),
      .bus_din(bus_din), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   function automatic int pick(bit r0, bit r1);
`ifdef IO_ARB_ROUND_ROBIN_EN
      if (r0 && r1) return pref;
`endif
      return r0 ? 0 : 1;
   endfunction

   task automatic model_reset();
      act = 1'b0; ph = 0; m_owner = 0; m_we = 1'b0; pref = 0;
      e_ack[0] = 1'b0; e_ack[1] = 1'b0; e_wen = 1'b0; e_ren = 1'b0; e_busy = 1'b0;
      e_addr = 8'h00; e_dout = 8'h00; e_rd[0] = 8'h00; e_rd[1] = 8'h00;
   endtask

   // Write: strobe one cycle after grant, ack after two, idle after three.
   // Read: strobe, then data capture, ack after three, idle after four.
   task automatic model_step();
      int l_ack;
      if (rst) begin
         model_reset();
         return;
      end
      e_ack[0] = 1'b0; e_ack[1] = 1'b0; e_wen = 1'b0; e_ren = 1'b0;
      if (!act) begin
         if (req[0] || req[1]) begin
            m_owner = pick(req[0], req[1]);
            m_we    = we[m_owner];
            e_addr  = addr[m_owner];
            e_dout  = wd[m_owner];
            e_wen   = m_we;
            e_ren   = !m_we;
            e_busy  = 1'b1;
            act     = 1'b1;
            ph      = 1;
         end
      end else begin
         ph++;
         l_ack = m_we ? 2 : 3;
         if (ph == l_ack) begin
            e_ack[m_owner] = 1'b1;
            if (!m_we) e_rd[m_owner] = bus_din;
         end else if (ph == l_ack + 1) begin
            act    = 1'b0;
            e_busy = 1'b0;
            pref   = 1 - m_owner;
         end
      end
   endtask

   task automatic compare_all();
      chk("m0_ack", m0_ack, e_ack[0]);
      chk("m1_ack", m1_ack, e_ack[1]);
      chk("bus_w_en", bus_w_en, e_wen);
      chk("bus_r_en", bus_r_en, e_ren);
      chk("busy", busy, e_busy);
      chk("bus_addr", bus_addr, e_addr);
      chk("bus_dout", bus_dout, e_dout);
      chk("m0_rdata", m0_rdata, e_rd[0]);
      chk("m1_rdata", m1_rdata, e_rd[1]);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic drive_random();
      logic acked;
      for (int i = 0; i < 2; i++) begin
         acked = (i == 0) ? m0_ack : m1_ack;
         if (acked || !req[i]) begin
            if ($urandom_range(0, 3) != 0) begin
               req[i]  = 1'b1;
               we[i]   = 1'($urandom_range(0, 1));
               addr[i] = 8'($urandom);
               wd[i]   = 8'($urandom);
            end else begin
               req[i] = 1'b0;
            end
         end
      end
      bus_din = 8'($urandom);
   endtask

   initial begin
      int acks[$];
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; we[i] = 1'b0; addr[i] = 8'h00; wd[i] = 8'h00;
      end
      bus_din = 8'h00;
      model_reset();
      tick();
      tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_bus_addr", bus_addr, 8'h00);
      chk("rst_m1_rdata", m1_rdata, 8'h00);
      rst = 1'b0;
      tick();

      // master 0 writes 0xA5 to 0x01
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h01; wd[0] = 8'hA5;
      tick();
      chk("wr_w_en_c1", bus_w_en, 1'b1);
      chk("wr_addr_c1", bus_addr, 8'h01);
      chk("wr_data_c1", bus_dout, 8'hA5);
      tick();
      chk("wr_ack_c2", m0_ack, 1'b1);
      chk("wr_w_en_c2", bus_w_en, 1'b0);
      chk("wr_m1_ack_c2", m1_ack, 1'b0);
      req[0] = 1'b0;
      tick();

      // master 1 reads 0x02, peripheral returns 0x3C
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'h02;
      tick();
      chk("rd_r_en_c1", bus_r_en, 1'b1);
      bus_din = 8'h3C;
      tick();
      chk("rd_ack_c2", m1_ack, 1'b0);
      tick();
      chk("rd_ack_c3", m1_ack, 1'b1);
      chk("rd_data_c3", m1_rdata, 8'h3C);
      req[1] = 1'b0; bus_din = 8'h00;
      tick();
      chk("rd_hold", m1_rdata, 8'h3C);

      // both masters write continuously
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h10; wd[0] = 8'h01;
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'h20; wd[1] = 8'h02;
      for (int c = 0; c < 11; c++) begin
         tick();
         if (m0_ack) acks.push_back(0);
         if (m1_ack) acks.push_back(1);
      end
      req[0] = 1'b0; req[1] = 1'b0;
      tick();
      chk("tie_ack_count", acks.size(), 4);
      for (int i = 0; i < acks.size() && i < 4; i++) begin
`ifdef IO_ARB_ROUND_ROBIN_EN
         chk("tie_winner", acks[i], i % 2);
`else
         chk("tie_winner", acks[i], 0);
`endif
      end

      // back-to-back with new address presented in the ack cycle
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h00; wd[0] = 8'h11;
      tick();
      chk("b2b_addr0", bus_addr, 8'h00);
      tick();
      chk("b2b_ack0", m0_ack, 1'b1);
      addr[0] = 8'h01;
      tick();
      chk("b2b_gap_w_en", bus_w_en, 1'b0);
      tick();
      chk("b2b_w_en1", bus_w_en, 1'b1);
      chk("b2b_addr1", bus_addr, 8'h01);
      tick();
      req[0] = 1'b0;
      tick();

      // req dropped after the grant: latched write still completes once
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h07; wd[0] = 8'h5A;
      tick();
      chk("drop_w_en", bus_w_en, 1'b1);
      req[0] = 1'b0; addr[0] = 8'h99;
      tick();
      chk("drop_ack", m0_ack, 1'b1);
      chk("drop_addr_held", bus_addr, 8'h07);
      tick();
      tick();
      chk("drop_no_reissue", bus_w_en, 1'b0);
      chk("drop_idle", busy, 1'b0);

      // reset pulsed during RWAIT
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'h03;
      tick();
      chk("rrst_r_en", bus_r_en, 1'b1);
      bus_din = 8'h77;
      tick();
      chk("rrst_busy_before", busy, 1'b1);
      rst = 1'b1; req[0] = 1'b0;
      model_reset();
      #1;
      compare_all();
      chk("rrst_r_en_low", bus_r_en, 1'b0);
      chk("rrst_m0_rdata", m0_rdata, 8'h00);
      tick();
      rst = 1'b0;
      tick();
      tick();
      chk("rrst_no_ack", m0_ack, 1'b0);
      chk("rrst_busy", busy, 1'b0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         drive_random();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
